// File: rtl/led_cube_scan_driver.sv
// ---------------------------------------------------------------------------
// led_cube_scan_driver
// Multiplexed scan driver for an LED wall/cube. Holds a double-buffered frame
// of LAYERS x LATCHES x DATA_W bits. Each layer slot is one BLANK cycle, then
// every column latch is loaded over the shared data bus (setup / strobe / hold),
// then the layer is driven for DWELL_CYCLES cycles. The producer writes the back
// bank; a requested swap takes effect on the frame_done cycle.
// Optional feature macro: BRIGHTNESS_PWM_EN adds a brightness[7:0] input that
// limits how many DRIVE cycles the layer enable is actually high.
// ---------------------------------------------------------------------------
module led_cube_scan_driver #(
    parameter int LAYERS       = 8,
    parameter int LATCHES      = 8,
    parameter int DATA_W       = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int LATCH_PULSE  = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          en,
    input  logic                                          wr_en,
    input  logic [$clog2(LAYERS)-1:0]                     wr_layer,
    input  logic [((LATCHES > 1) ? $clog2(LATCHES) : 1)-1:0] wr_latch,
    input  logic [DATA_W-1:0]                             wr_data,
    input  logic                                          swap_req,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [7:0]                                    brightness,
`endif
    output logic                                          swap_ack,
    output logic                                          frame_done,
    output logic [DATA_W-1:0]                             data_out,
    output logic [LATCHES-1:0]                            latch_out,
    output logic [LAYERS-1:0]                             layer_out
);

    localparam int LY_W = $clog2(LAYERS);
    localparam int LT_W = (LATCHES > 1) ? $clog2(LATCHES) : 1;
    localparam int PH_W = $clog2(LATCH_PULSE + 2);
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    localparam logic [LY_W-1:0] LAYER_LAST = LY_W'(LAYERS - 1);
    localparam logic [LT_W-1:0] LATCH_LAST = LT_W'(LATCHES - 1);
    localparam logic [PH_W-1:0] PH_HOLD    = PH_W'(LATCH_PULSE + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_DRIVE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [LY_W-1:0] layer_q, layer_d;
    logic [LT_W-1:0] latch_q, latch_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            front_q, front_d;
    logic            pend_q, pend_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic            load_last;
    logic            drive_on;
    logic            wr_ok;
    logic [DATA_W-1:0] front_word;

    // Bank 0/1 storage; front_q selects the bank being scanned.
    logic [1:0][LAYERS-1:0][LATCHES-1:0][DATA_W-1:0] bank_q, bank_d;

    assign front_word = bank_q[front_q][layer_q][latch_q];
    assign wr_ok      = wr_en
                     && ({1'b0, wr_layer} < (LY_W + 1)'(LAYERS))
                     && ({1'b0, wr_latch} < (LT_W + 1)'(LATCHES));
    assign frame_done = (state_q == S_DRIVE) && (dwell_q == DWELL_LAST)
                     && (layer_q == LAYER_LAST);
    assign swap_ack   = frame_done && (pend_q || swap_req);

`ifdef BRIGHTNESS_PWM_EN
    localparam logic [DW_W+7:0] DWELL_EXT = (DW_W + 8)'(DWELL_CYCLES);
    logic [DW_W+7:0] pwm_prod;
    logic [DW_W-1:0] on_q, on_d;

    assign pwm_prod = DWELL_EXT * {{DW_W{1'b0}}, brightness};
    assign on_d     = load_last ? pwm_prod[DW_W+7:8] : on_q;
    assign drive_on = (dwell_q < on_q);

    // On-time register, sampled as the layer enters DRIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) on_q <= '0;
        else        on_q <= on_d;
    end
`else
    assign drive_on = 1'b1;
`endif

    // Scan sequencer: BLANK -> LOAD (setup/strobe/hold per latch) -> DRIVE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d   = state_q;
        layer_d   = layer_q;
        latch_d   = latch_q;
        phase_d   = phase_q;
        dwell_d   = dwell_q;
        load_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                layer_d = '0;
                if (en) state_d = S_BLANK;
            end
            S_BLANK: begin
                state_d = S_LOAD;
                latch_d = '0;
                phase_d = '0;
            end
            S_LOAD: begin
                if (phase_q == PH_HOLD) begin
                    phase_d = '0;
                    if (latch_q == LATCH_LAST) begin
                        state_d   = S_DRIVE;
                        dwell_d   = '0;
                        load_last = 1'b1;
                    end else begin
                        latch_d = latch_q + 1'b1;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    state_d = S_BLANK;
                    layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d = S_IDLE;
            layer_d = '0;
        end
    end

    // Bank select, sticky swap request, held data word and back-bank writes.
    always_comb begin
        front_d = front_q ^ swap_ack;
        pend_d  = swap_ack ? 1'b0 : (pend_q | swap_req);
        data_d  = (state_q == S_LOAD) ? front_word : data_q;
        bank_d  = bank_q;
        if (wr_ok) bank_d[~front_q][wr_layer][wr_latch] = wr_data;
    end

    // State registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            latch_q <= '0;
            phase_q <= '0;
            dwell_q <= '0;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            // NOTE: the frame banks are reset too, so a fresh scan shows a dark frame.
            bank_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating in parallel.
            state_q <= state_d;
            layer_q <= layer_d;
            latch_q <= latch_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            front_q <= front_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            bank_q  <= bank_d;
        end
    end

    // Output decode: strobes only in the pulse phase, layer only in DRIVE.
    always_comb begin
        latch_out = '0;
        layer_out = '0;
        if (state_q == S_LOAD && phase_q != '0 && phase_q != PH_HOLD)
            latch_out[latch_q] = 1'b1;
        if (state_q == S_DRIVE && drive_on)
            layer_out[layer_q] = 1'b1;
        case (state_q)
            S_IDLE:  data_out = '0;
            S_LOAD:  data_out = front_word;
            default: data_out = data_q;
        endcase
    end

endmodule
